// File: rtl/saph_elastic_pipe.sv
// saph_elastic_pipe: elastic valid/ready stage with depth-entry circular skid storage.
// Ready and valid come from registered occupancy only, so no combinational path crosses the stage.
module saph_elastic_pipe #(
    parameter int width = 32,
    parameter int depth = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [width-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [width-1:0]           out_data,
    output logic [$clog2(depth+1)-1:0] count
);
    localparam int cw = $clog2(depth + 1);
    localparam int pw = $clog2(depth);
    localparam logic [cw-1:0] full = cw'(depth);
    localparam logic [pw-1:0] last = pw'(depth - 1);

    logic [width-1:0] mem [depth];
    logic [pw-1:0]    rptr, wptr;
    logic             push, pop;

    assign in_ready  = !rst && (count < full);
    assign out_valid = count != '0;
    assign out_data  = out_valid ? mem[rptr] : '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
            for (int i = 0; i < depth; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= '0;
            rptr  <= '0;
            wptr  <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= in_data;
                wptr      <= (wptr == last) ? '0 : wptr + 1'b1;
            end
            if (pop) rptr <= (rptr == last) ? '0 : rptr + 1'b1;
            count <= count + cw'(push) - cw'(pop);
        end
    end

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && count == full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
    a_count_range:  assert property (@(posedge clk) disable iff (rst) count <= full);
endmodule

// File: tb/tb_saph_elastic_pipe.sv
// tb_saph_elastic_pipe: depth-2 and depth-3 stages share stimulus; each is checked against a queue model.
module tb_saph_elastic_pipe;
    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_data = 0;
    logic        ir2, ov2, ir3, ov3;
    logic [31:0] od2, od3;
    logic [1:0]  c2, c3;
    logic [31:0] q2[$], q3[$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    saph_elastic_pipe #(.width(32), .depth(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(c2));
    saph_elastic_pipe #(.width(32), .depth(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3), .in_data(in_data),
        .out_valid(ov3), .out_ready(out_ready), .out_data(od3), .count(c3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cmp(input string n, input logic ir, input logic ov, input logic [31:0] od,
                       input logic [1:0] c, input int sz, input logic [31:0] head, input int d);
        check({n, ".in_ready"}, 32'(ir), 32'(!rst && sz < d));
        check({n, ".out_valid"}, 32'(ov), 32'(sz != 0));
        check({n, ".out_data"}, od, sz != 0 ? head : 32'h0);
        check({n, ".count"}, 32'(c), 32'(sz));
    endtask

    // Compare before the edge, then advance the model with the inputs the edge will sample.
    task automatic tick();
        @(negedge clk);
        cmp("d2", ir2, ov2, od2, c2, q2.size(), q2.size() != 0 ? q2[0] : 32'h0, 2);
        cmp("d3", ir3, ov3, od3, c3, q3.size(), q3.size() != 0 ? q3[0] : 32'h0, 3);
        if (rst || flush) begin
            q2.delete();
            q3.delete();
        end else begin
            bit p2, p3;
            p2 = in_valid && q2.size() < 2;
            p3 = in_valid && q3.size() < 3;
            if (out_ready && q2.size() > 0) void'(q2.pop_front());
            if (out_ready && q3.size() > 0) void'(q3.pop_front());
            if (p2) q2.push_back(in_data);
            if (p3) q3.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid = 0;
        out_ready = 1;
        repeat (4) tick();
    endtask

    initial begin
        logic [31:0] stream [4];
        stream = '{32'h11, 32'h22, 32'h33, 32'h44};
        @(posedge clk);
        #1;
        repeat (2) tick();
        rst = 0;
        #1;
        check("rst.in_ready", 32'(ir2), 32'd1);
        check("rst.out_valid", 32'(ov3), 32'd0);
        check("rst.count", 32'(c3), 32'd0);
        check("rst.out_data", od2, 32'h0);
        tick();

        out_ready = 1;
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = stream[i];
            tick();
            check("stream.out_data", od2, stream[i]);
            check("stream.count", 32'(c2), 32'd1);
            check("stream.in_ready", 32'(ir2), 32'd1);
        end
        drain();

        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hA + 32'(i);
            tick();
        end
        check("bp.count", 32'(c3), 32'd3);
        check("bp.in_ready", 32'(ir3), 32'd0);
        check("bp.head", od3, 32'hA);
        out_ready = 1;
        repeat (2) tick();
        in_valid = 0;
        repeat (5) tick();

        out_ready = 0;
        in_valid = 1;
        in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        in_data = 32'h55;
        out_ready = 1;
        #1;
        check("full.count", 32'(c2), 32'd2);
        check("full.in_ready", 32'(ir2), 32'd0);
        tick();
        check("full.pop_count", 32'(c2), 32'd1);
        check("full.reready", 32'(ir2), 32'd1);
        out_ready = 0;
        tick();
        check("full.refill", 32'(c2), 32'd2);
        drain();

        out_ready = 0;
        in_valid = 1;
        in_data = 32'h1;
        tick();
        in_data = 32'h2;
        tick();
        flush = 1;
        in_data = 32'h9;
        out_ready = 1;
        tick();
        flush = 0;
        in_valid = 0;
        check("flush.count", 32'(c2), 32'd0);
        check("flush.out_valid", 32'(ov2), 32'd0);
        check("flush.in_ready", 32'(ir3), 32'd1);
        check("flush.out_data", od3, 32'h0);
        repeat (3) tick();

        repeat (300) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data = $urandom;
            flush = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 0;
        drain();

        out_ready = 0;
        in_valid = 1;
        in_data = 32'hBEEF;
        tick();
        in_data = 32'hCAFE;
        tick();
        check("midrst.pre_count", 32'(c3), 32'd2);
        in_valid = 0;
        rst = 1;
        tick();
        check("midrst.count", 32'(c3), 32'd0);
        check("midrst.out_valid", 32'(ov3), 32'd0);
        check("midrst.out_data", od3, 32'h0);
        rst = 0;
        out_ready = 1;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/saph_elastic_pipe.md
Name: saph_elastic_pipe

Overview:
- Elastic pipeline stage with a valid/ready handshake and depth-entry skid storage. It sits directly upstream of fixed-latency pipeline-register chains.
- It absorbs downstream back-pressure so that stalling producers need no combinational ready path through the datapath.
- Typical placement: between a shader-core issue stage and the fixed-latency arithmetic pipeline that follows it.

Parameters:
- width, 32, data bits per entry.
- depth, 2, storage entries; legal range 2..16; depth >= 2 guarantees full throughput.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  synchronous active-high reset; clears all state to 0.
- flush  input  1  synchronous discard of all stored entries.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  stage can accept an entry this cycle.
- in_data  input  width  upstream payload.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_data  output  width  head entry payload.
- count  output  $clog2(depth+1)  number of stored entries.

Behaviour:
- Reset (rst=1 at a clk edge): count=0, out_valid=0, in_ready=0 during reset, out_data=0, all storage entries=0, read/write pointers=0. From the first cycle after rst deasserts, in_ready=1.
- Storage is a circular buffer of depth entries with a read pointer, a write pointer and count. Pointers wrap from depth-1 to 0. Non-power-of-two depth must wrap correctly.
- Push: occurs when in_valid && in_ready at a clk edge. in_data is written at the write pointer, and the write pointer advances.
- Pop: occurs when out_valid && out_ready at a clk edge. The read pointer advances.
- count update: count_next = count + push - pop.
- Ready and valid sources:
  - in_ready = !rst && (count < depth). It is a function of registered state only, with no combinational dependence on out_ready or in_valid.
  - out_valid = (count != 0). Registered state only.
  - out_data = entry at the read pointer; it reads as 0 while count == 0.
- Latency: an entry pushed into an empty stage at edge N appears on out_valid/out_data in cycle N+1. There is no same-cycle in-to-out path.
- Throughput: with depth >= 2 and out_ready held at 1, one entry per cycle is sustained indefinitely.
- Full (count == depth):
  - in_ready=0; in_valid is ignored and in_data is not written.
  - A simultaneous pop still occurs; in_ready rises in the following cycle.
- Empty (count == 0): out_valid=0 and out_ready is ignored, so no underflow is possible. A push in this cycle is accepted normally.
- Simultaneous push and pop with 0 < count < depth: both happen and count is unchanged. Order is preserved strictly FIFO.
- Handshake rules on the downstream side:
  - Once out_valid=1, out_valid and out_data are stable until a pop or a flush.
  - Upstream holding in_valid while in_ready=0 is legal and causes no side effect.
- flush=1 at an edge: count=0 and both pointers=0. Any push or pop requested in that cycle is discarded. Storage contents need not be cleared, but out_data must still read 0 because count==0. The cycle after the flush shows out_valid=0 and in_ready=1.
- rst has priority over flush. Both are fully synchronous; asserting rst mid-stream drops all entries with no partial output.
- Simulation-only assertions:
  - No push while count == depth.
  - No pop while count == 0.
  - count never exceeds depth.

Test Plan:
- Reset, then idle: rst held 3 cycles, then released -> cycle after release shows in_ready=1, out_valid=0, count=0, out_data=0.
- Streaming, depth=2, width=32: push 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1 -> out_data is 0x11..0x44 in the 4 cycles starting one cycle after the first push; in_ready stays 1 and count stays at 1.
- Back-pressure, depth=3: out_ready=0, push 0xA,0xB,0xC,0xD held valid -> count reaches 3 and in_ready=0; 0xD is held off. Raise out_ready -> outputs 0xA,0xB,0xC,0xD in order with no loss or duplication.
- Full with simultaneous pop and push request, depth=2: count=2, in_valid=1 with 0x55, out_ready=1 -> pop happens, 0x55 is not accepted that cycle; next cycle in_ready=1 and 0x55 is accepted; count returns to 2 only after that push.
- Flush: count=2 holding 0x1,0x2; assert flush together with in_valid=1 (0x9) and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; 0x9 never appears at the output.
- Wrap-around and reset mid-stream, depth=3: 10 random pushes/pops with random stalls -> output order matches a reference FIFO across pointer wraps. rst asserted while count=2 -> next cycle count=0, out_valid=0, out_data=0.
